// File: rtl/turn_controller.sv
`default_nettype none
// ============================================================================
// Module : turn_controller
// Desc   : PS/2 set-2 move entry (letter, number, Enter) with board req/ack
// Rev    : 1.0
// ============================================================================
module turn_controller #(
  parameter int GRID_SIZE   = 10,
  parameter int ACK_TIMEOUT = 1048576
) (
  input  logic       clock27,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       move_ack,
  input  logic       move_reject,
  output logic       player_turn,
  output logic [3:0] letter_idx,
  output logic       letter_present,
  output logic [3:0] number_idx,
  output logic       number_present,
  output logic       move_req,
  output logic       entry_error
);

  localparam int         CNT_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [4:0] GRID_LIM  = 5'(GRID_SIZE);
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef enum logic [1:0] {
    WAIT_LETTER = 2'd0,
    WAIT_NUMBER = 2'd1,
    WAIT_ENTER  = 2'd2,
    WAIT_ACK    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               player_q, player_d;
  logic [3:0]         letter_idx_q, letter_idx_d;
  logic               letter_present_q, letter_present_d;
  logic [3:0]         number_idx_q, number_idx_d;
  logic               number_present_q, number_present_d;
  logic               move_req_q, move_req_d;
  logic               entry_error_q, entry_error_d;
  logic               brk_q, brk_d;
  logic               ext_q, ext_d;
  logic [CNT_W-1:0]   ack_cnt_q, ack_cnt_d;

  logic       letter_hit, digit_hit, letter_ok, digit_ok, key_use, ack_expired;
  logic [3:0] letter_code, digit_code;

  always_comb begin
    letter_hit  = 1'b1;
    letter_code = 4'd0;
    case (key_code)
      8'h1C: letter_code = 4'd0;
      8'h32: letter_code = 4'd1;
      8'h21: letter_code = 4'd2;
      8'h23: letter_code = 4'd3;
      8'h24: letter_code = 4'd4;
      8'h2B: letter_code = 4'd5;
      8'h34: letter_code = 4'd6;
      8'h33: letter_code = 4'd7;
      8'h43: letter_code = 4'd8;
      8'h3B: letter_code = 4'd9;
      default: letter_hit = 1'b0;
    endcase
    digit_hit  = 1'b1;
    digit_code = 4'd0;
    case (key_code)
      8'h45: digit_code = 4'd0;
      8'h16: digit_code = 4'd1;
      8'h1E: digit_code = 4'd2;
      8'h26: digit_code = 4'd3;
      8'h25: digit_code = 4'd4;
      8'h2E: digit_code = 4'd5;
      8'h36: digit_code = 4'd6;
      8'h3D: digit_code = 4'd7;
      8'h3E: digit_code = 4'd8;
      8'h46: digit_code = 4'd9;
      default: digit_hit = 1'b0;
    endcase
  end

  assign letter_ok   = letter_hit && ({1'b0, letter_code} < GRID_LIM);
  assign digit_ok    = digit_hit  && ({1'b0, digit_code}  < GRID_LIM);
  assign ack_expired = (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  // Prefix filter: a byte after F0 is dropped; after E0 the next byte is
  // dropped too, and if that byte is F0 the one after it goes as well.
  always_comb begin
    key_use = 1'b0;
    brk_d   = brk_q;
    ext_d   = ext_q;
    if (key_valid) begin
      if (ext_q) begin
        ext_d = 1'b0;
        brk_d = (key_code == KEY_BREAK);
      end else if (brk_q) begin
        brk_d = 1'b0;
      end else if (key_code == KEY_BREAK) begin
        brk_d = 1'b1;
      end else if (key_code == KEY_EXT) begin
        ext_d = 1'b1;
      end else begin
        key_use = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    player_d         = player_q;
    letter_idx_d     = letter_idx_q;
    letter_present_d = letter_present_q;
    number_idx_d     = number_idx_q;
    number_present_d = number_present_q;
    move_req_d       = move_req_q;
    entry_error_d    = 1'b0;
    ack_cnt_d        = ack_cnt_q;
    case (state_q)
      WAIT_LETTER: begin
        if (key_use) begin
          if (letter_ok) begin
            letter_idx_d     = letter_code;
            letter_present_d = 1'b1;
            state_d          = WAIT_NUMBER;
          end else if (key_code != KEY_BKSP && key_code != KEY_ESC) begin
            entry_error_d = 1'b1;
          end
        end
      end
      WAIT_NUMBER: begin
        if (key_use) begin
          if (digit_ok) begin
            number_idx_d     = digit_code;
            number_present_d = 1'b1;
            state_d          = WAIT_ENTER;
          end else if (key_code == KEY_BKSP) begin
            letter_present_d = 1'b0;
            state_d          = WAIT_LETTER;
          end else if (key_code == KEY_ESC) begin
            letter_present_d = 1'b0;
            number_present_d = 1'b0;
            state_d          = WAIT_LETTER;
          end else begin
            entry_error_d = 1'b1;
          end
        end
      end
      WAIT_ENTER: begin
        if (key_use) begin
          if (key_code == KEY_ENTER) begin
            move_req_d = 1'b1;
            ack_cnt_d  = '0;
            state_d    = WAIT_ACK;
          end else if (key_code == KEY_BKSP) begin
            number_present_d = 1'b0;
            state_d          = WAIT_NUMBER;
          end else if (key_code == KEY_ESC) begin
            letter_present_d = 1'b0;
            number_present_d = 1'b0;
            state_d          = WAIT_LETTER;
          end else begin
            entry_error_d = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        // A timeout is treated exactly like a reject; reject beats ack.
        if (move_reject || move_ack || ack_expired) begin
          move_req_d       = 1'b0;
          letter_present_d = 1'b0;
          number_present_d = 1'b0;
          state_d          = WAIT_LETTER;
          if (move_reject || !move_ack) begin
            entry_error_d = 1'b1;
          end else begin
            player_d = ~player_q;
          end
        end else begin
          ack_cnt_d = ack_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_LETTER;
    endcase
  end

  always_ff @(posedge clock27) begin
    if (reset) begin
      state_q          <= WAIT_LETTER;
      player_q         <= 1'b0;
      letter_idx_q     <= 4'd0;
      letter_present_q <= 1'b0;
      number_idx_q     <= 4'd0;
      number_present_q <= 1'b0;
      move_req_q       <= 1'b0;
      entry_error_q    <= 1'b0;
      brk_q            <= 1'b0;
      ext_q            <= 1'b0;
      ack_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      player_q         <= player_d;
      letter_idx_q     <= letter_idx_d;
      letter_present_q <= letter_present_d;
      number_idx_q     <= number_idx_d;
      number_present_q <= number_present_d;
      move_req_q       <= move_req_d;
      entry_error_q    <= entry_error_d;
      brk_q            <= brk_d;
      ext_q            <= ext_d;
      ack_cnt_q        <= ack_cnt_d;
    end
  end

  assign player_turn    = player_q;
  assign letter_idx     = letter_idx_q;
  assign letter_present = letter_present_q;
  assign number_idx     = number_idx_q;
  assign number_present = number_present_q;
  assign move_req       = move_req_q;
  assign entry_error    = entry_error_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_turn_controller
// Desc   : two turn_controller instances (grid 10 / grid 5) vs. reference model
// Rev    : 1.0
// ============================================================================
module tb_turn_controller;

  localparam int G0 = 10;
  localparam int T0 = 16;
  localparam int G1 = 5;
  localparam int T1 = 24;

  logic       clock27 = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       move_ack = 1'b0;
  logic       move_reject = 1'b0;

  logic       pt0, lp0, np0, req0, err0;
  logic [3:0] li0, ni0;
  logic       pt1, lp1, np1, req1, err1;
  logic [3:0] li1, ni1;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock27 = ~clock27;

  turn_controller #(.GRID_SIZE(G0), .ACK_TIMEOUT(T0)) u_dut0 (
    .clock27(clock27), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .move_ack(move_ack), .move_reject(move_reject), .player_turn(pt0),
    .letter_idx(li0), .letter_present(lp0), .number_idx(ni0), .number_present(np0),
    .move_req(req0), .entry_error(err0)
  );

  turn_controller #(.GRID_SIZE(G1), .ACK_TIMEOUT(T1)) u_dut1 (
    .clock27(clock27), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .move_ack(move_ack), .move_reject(move_reject), .player_turn(pt1),
    .letter_idx(li1), .letter_present(lp1), .number_idx(ni1), .number_present(np1),
    .move_req(req1), .entry_error(err1)
  );

  // Reference model: phase 0=letter,1=number,2=enter,3=awaiting board.
  typedef struct packed {
    logic [1:0]  ph;
    logic        pl;
    logic [3:0]  li;
    logic        lp;
    logic [3:0]  ni;
    logic        np;
    logic        req;
    logic        err;
    logic        brk;
    logic        ext;
    logic [31:0] waited;
  } mdl_t;

  mdl_t m0, m1;

  logic [7:0] letter_codes [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                                    8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
  logic [7:0] digit_codes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic int letter_of(logic [7:0] kc, int grid);
    for (int i = 0; i < grid; i++) if (letter_codes[i] == kc) return i;
    return -1;
  endfunction

  function automatic int digit_of(logic [7:0] kc, int grid);
    for (int i = 0; i < grid; i++) if (digit_codes[i] == kc) return i;
    return -1;
  endfunction

  function automatic mdl_t step(mdl_t m, int grid, int tmo, logic rst, logic kv,
                                logic [7:0] kc, logic ack, logic rej);
    mdl_t n;
    logic use_key;
    int   li, di;
    n = m;
    n.err = 1'b0;
    if (rst) return '0;
    use_key = 1'b0;
    if (kv) begin
      if (m.ext) begin
        n.ext = 1'b0;
        n.brk = (kc == 8'hF0);
      end else if (m.brk) n.brk = 1'b0;
      else if (kc == 8'hF0) n.brk = 1'b1;
      else if (kc == 8'hE0) n.ext = 1'b1;
      else use_key = 1'b1;
    end
    li = letter_of(kc, grid);
    di = digit_of(kc, grid);
    if (m.ph == 2'd3) begin
      if (ack || rej || m.waited == 32'(tmo - 1)) begin
        n.req = 1'b0; n.lp = 1'b0; n.np = 1'b0; n.ph = 2'd0;
        if (ack && !rej) n.pl = ~m.pl;
        else n.err = 1'b1;
      end else n.waited = m.waited + 1;
    end else if (use_key) begin
      if (m.ph == 2'd0) begin
        if (li >= 0) begin n.li = 4'(li); n.lp = 1'b1; n.ph = 2'd1; end
        else if (kc != 8'h66 && kc != 8'h76) n.err = 1'b1;
      end else if (m.ph == 2'd1) begin
        if (di >= 0) begin n.ni = 4'(di); n.np = 1'b1; n.ph = 2'd2; end
        else if (kc == 8'h66) begin n.lp = 1'b0; n.ph = 2'd0; end
        else if (kc == 8'h76) begin n.lp = 1'b0; n.np = 1'b0; n.ph = 2'd0; end
        else n.err = 1'b1;
      end else begin
        if (kc == 8'h5A) begin n.req = 1'b1; n.waited = 0; n.ph = 2'd3; end
        else if (kc == 8'h66) begin n.np = 1'b0; n.ph = 2'd1; end
        else if (kc == 8'h76) begin n.lp = 1'b0; n.np = 1'b0; n.ph = 2'd0; end
        else n.err = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input mdl_t m, input logic pt, input logic [3:0] li,
                           input logic lp, input logic [3:0] ni, input logic np,
                           input logic req, input logic err);
    check_eq({nm, ".player_turn"},    32'(pt),  32'(m.pl));
    check_eq({nm, ".letter_present"}, 32'(lp),  32'(m.lp));
    check_eq({nm, ".number_present"}, 32'(np),  32'(m.np));
    check_eq({nm, ".move_req"},       32'(req), 32'(m.req));
    check_eq({nm, ".entry_error"},    32'(err), 32'(m.err));
    // Index values only matter to the display while present, or while the move is held.
    if (m.lp || m.req) check_eq({nm, ".letter_idx"}, 32'(li), 32'(m.li));
    if (m.np || m.req) check_eq({nm, ".number_idx"}, 32'(ni), 32'(m.ni));
  endtask

  task automatic do_cycle(input logic rst, input logic kv, input logic [7:0] kc,
                          input logic ack, input logic rej);
    reset       = rst;
    key_valid   = kv;
    key_code    = kc;
    move_ack    = ack;
    move_reject = rej;
    @(posedge clock27);
    m0 = step(m0, G0, T0, rst, kv, kc, ack, rej);
    m1 = step(m1, G1, T1, rst, kv, kc, ack, rej);
    @(negedge clock27);
    check_dut("g10", m0, pt0, li0, lp0, ni0, np0, req0, err0);
    check_dut("g5",  m1, pt1, li1, lp1, ni1, np1, req1, err1);
  endtask

  task automatic key(input logic [7:0] kc);
    do_cycle(1'b0, 1'b1, kc, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 25) return letter_codes[$urandom_range(0, 9)];
    if (r < 50) return digit_codes[$urandom_range(0, 9)];
    if (r < 65) return 8'h5A;
    if (r < 72) return 8'h66;
    if (r < 77) return 8'h76;
    if (r < 85) return 8'hF0;
    if (r < 90) return 8'hE0;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    m0 = '0;
    m1 = '0;
    @(negedge clock27);
    do_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    // Basic move, accepted three cycles after Enter.
    key(8'h1C); idle(1); key(8'h16); idle(1); key(8'h5A); idle(3);
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); idle(2);
    // Break and extended prefixes.
    key(8'hF0); key(8'h1C); key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h1C);
    key(8'h32); key(8'h76);
    // Grid boundary letters/digits.
    key(8'h2B); key(8'h24); key(8'h46); key(8'h25); key(8'h66); key(8'h66); key(8'h3B);
    // Backspace/escape chain.
    key(8'h21); key(8'h26); key(8'h66); key(8'h66); key(8'h21); key(8'h26); key(8'h76);
    // Simultaneous ack+reject.
    key(8'h1C); key(8'h45); key(8'h5A); key(8'h1C);
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); idle(1);
    // No response: both timeouts.
    key(8'h32); key(8'h16); key(8'h5A); idle(30);
    // Accepted move, then reset while the next one is pending.
    key(8'h1C); key(8'h16); key(8'h5A); do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    key(8'h23); key(8'h1E); key(8'h5A); idle(2);
    do_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    key(8'h32); key(8'h45); idle(2);
    // Late ack outside the wait phase.
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      do_cycle(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), rand_key(),
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0));
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/turn_controller.md
Name: turn_controller

Overview:
Sequences move entry for the two-player grid game. It decodes PS/2 set-2 scancode bytes into a letter (row) and a number (column), and waits for Enter. It then presents the move to the game board with a req/ack handshake and toggles the active player when the board accepts the move. Its outputs drive the hex display controller: player turn, entered letter and entered number.

Parameters:
GRID_SIZE, 10, number of valid rows/columns (letters A.., digits 0..); legal range 1..10
ACK_TIMEOUT, 1048576, clock27 cycles to wait for move_ack/move_reject before aborting (~39 ms)

Ports:
clock27  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  one-cycle strobe: key_code holds a new scancode byte
key_code  input  8  PS/2 set-2 scancode byte
move_ack  input  1  board accepted the presented move
move_reject  input  1  board refused the move (cell already used)
player_turn  output  1  0 = player 1, 1 = player 2
letter_idx  output  4  entered row, 0=A .. 9=J
letter_present  output  1  letter_idx is valid
number_idx  output  4  entered column 0..9
number_present  output  1  number_idx is valid
move_req  output  1  move on letter_idx/number_idx awaiting the board
entry_error  output  1  one-cycle pulse on invalid key, reject or timeout

Behaviour:
- All outputs are registered. A key's effect is visible on the cycle after its key_valid strobe.
- Reset (wins over every other input): state WAIT_LETTER, player_turn=0, letter/number idx=0, present flags=0, move_req=0, entry_error=0, prefix flags cleared, timeout counter=0.
- Prefix filter runs in every state:
  - F0 sets break_pending; the next byte is discarded and break_pending is cleared.
  - E0 sets ext_pending; the next byte is discarded (including a following F0 and the byte after that).
  - Prefix bytes themselves produce no error.
- Key map:
  - Letters A-J = 1C,32,21,23,24,2B,34,33,43,3B.
  - Digits 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46.
  - Enter=5A, Backspace=66, Escape=76.
  - A letter or digit with index >= GRID_SIZE counts as unmapped.
- States:
  - WAIT_LETTER:
    - letter -> latch letter_idx, letter_present=1, go WAIT_NUMBER.
    - Backspace/Escape -> no change, no error.
    - Other key -> entry_error pulse.
  - WAIT_NUMBER:
    - digit -> latch number_idx, number_present=1, go WAIT_ENTER.
    - Backspace -> letter_present=0, go WAIT_LETTER.
    - Escape -> clear both present flags, go WAIT_LETTER.
    - Other key -> error pulse, no state change.
  - WAIT_ENTER:
    - Enter -> move_req=1, timeout counter cleared, go WAIT_ACK.
    - Backspace -> number_present=0, go WAIT_NUMBER.
    - Escape -> clear both, go WAIT_LETTER.
    - Other key -> error pulse.
  - WAIT_ACK:
    - Keys are ignored (prefix filter still tracks them).
    - letter_idx/number_idx are held stable while move_req=1.
    - move_reject (wins if asserted together with move_ack) -> move_req=0, clear both present flags, entry_error pulse, go WAIT_LETTER, player unchanged.
    - move_ack -> move_req=0, clear both present flags, player_turn toggles, go WAIT_LETTER.
    - Counter reaching ACK_TIMEOUT-1 with no response -> behaves as reject.
- move_req falls on the cycle after ack/reject is sampled. A late ack arriving outside WAIT_ACK is ignored.
- Reset during WAIT_ACK: move_req=0 on the next edge; the pending move is dropped.
- When a present flag is 0, its idx holds the last value; the display consumer blanks on present=0.

Test Plan:
- Reset, then strobe 1C, 16, 5A, then pulse move_ack 3 cycles later -> after 1C letter_idx=0/present=1; after 16 number_idx=1; move_req=1 after 5A; after ack move_req=0, presents=0, player_turn=1.
- In WAIT_LETTER send F0,1C -> no state change, no error. Then send E0,75 -> ignored. Then send 32 -> letter_idx=1.
- GRID_SIZE=5: send 24 (E, index 4) -> accepted; send 2B (F) at reset-fresh entry -> entry_error one pulse, letter_present stays 0. Send 46 as a digit (9) -> error pulse.
- Enter 21,26: Backspace -> number_present=0, state WAIT_NUMBER. Backspace again -> letter_present=0. Escape in WAIT_ENTER -> both flags 0.
- In WAIT_ACK, assert move_ack and move_reject together -> error pulse, player_turn unchanged, presents cleared. With ACK_TIMEOUT=16 and no response -> move_req drops after 16 cycles with an error pulse.
- Assert reset while move_req=1 and player_turn=1 -> next cycle move_req=0, player_turn=0, state WAIT_LETTER. Subsequent keys decode normally.
